// File: rtl/eeprom_pkg.sv
// Shared types and config-word layout for the EEPROM self-test sequencer.
package eeprom_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        TWR_DLY,
        RD_REQ,
        RD_WAIT,
        CMP,
        FINISH
    } state_t;

    localparam int DEV_MSB  = 31;
    localparam int RW_BIT   = 24;
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

    localparam logic RW_RD = 1'b1;
    localparam logic RW_WR = 1'b0;

    function automatic logic [31:0] mk_cmd(input logic [6:0]  dev,
                                           input logic        rw,
                                           input logic [15:0] addr,
                                           input logic [7:0]  data);
        logic [31:0] w;
        w                     = '0;
        w[DEV_MSB -: 7]       = dev;
        w[RW_BIT]             = rw;
        w[ADDR_MSB:ADDR_LSB]  = addr;
        w[DATA_MSB:0]         = data;
        return w;
    endfunction

endpackage

// File: rtl/eeprom_twr_timer.sv
// Write-cycle delay down-counter: load arms it, expired is high on the last
// counted cycle so the owner spends exactly CYCLES cycles waiting.
module eeprom_twr_timer #(
    parameter int CYCLES = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/eeprom_bist_seq.sv
// EEPROM write/read-back self-test sequencer driving the I2C byte controller.
// Optional EEPROM_BIST_STOP_ON_ERR_EN: abort the read-back at the first mismatch.
module eeprom_bist_seq
    import eeprom_pkg::*;
#(
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          TWR_US    = 5,
    parameter int          NUM_BYTES = 16,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [6:0]  DEV_ADDR  = 7'h50,
    parameter logic [7:0]  SEED      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        test_start,
    output logic [31:0] eeprom_config_data,
    output logic        i2c_start,
    input  logic        i2c_done,
    input  logic [7:0]  i2c_rd_data,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic [7:0]  err_cnt,
    output logic [7:0]  last_rd_data
);
    localparam int         TWR_CYC  = CLK_FREQ / 1_000_000 * TWR_US;
    localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

    state_t      state, state_nxt;
    logic [7:0]  idx;
    logic [15:0] addr;
    logic [7:0]  pattern;
    logic        is_last, mismatch;
    logic        accept, ld_wr, ld_rd, idx_clr, idx_inc, cap_rd, err_inc, finish;
    logic        tmr_load, tmr_expired;

    assign addr     = BASE_ADDR + {8'h00, idx};
    assign pattern  = idx ^ SEED;
    assign is_last  = (idx == LAST_IDX);
    assign mismatch = (last_rd_data != pattern);

    eeprom_twr_timer #(.CYCLES(TWR_CYC)) u_twr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .en      (state == TWR_DLY),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ld_wr     = 1'b0;
        ld_rd     = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        cap_rd    = 1'b0;
        err_inc   = 1'b0;
        finish    = 1'b0;
        tmr_load  = 1'b0;
        case (state)
            IDLE: if (test_start) begin
                accept    = 1'b1;
                state_nxt = WR_REQ;
            end
            WR_REQ: begin
                ld_wr     = 1'b1;
                state_nxt = WR_WAIT;
            end
            WR_WAIT: if (i2c_done) begin
                tmr_load  = 1'b1;
                state_nxt = TWR_DLY;
            end
            TWR_DLY: if (tmr_expired) begin
                if (is_last) begin
                    idx_clr   = 1'b1;
                    state_nxt = RD_REQ;
                end else begin
                    idx_inc   = 1'b1;
                    state_nxt = WR_REQ;
                end
            end
            RD_REQ: begin
                ld_rd     = 1'b1;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: if (i2c_done) begin
                cap_rd    = 1'b1;
                state_nxt = CMP;
            end
            CMP: begin
                err_inc = mismatch;
`ifdef EEPROM_BIST_STOP_ON_ERR_EN
                if (mismatch || is_last) begin
                    state_nxt = FINISH;
                end else begin
                    idx_inc   = 1'b1;
                    state_nxt = RD_REQ;
                end
`else
                if (is_last) begin
                    state_nxt = FINISH;
                end else begin
                    idx_inc   = 1'b1;
                    state_nxt = RD_REQ;
                end
`endif
            end
            FINISH: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command word only changes in the REQ states, so it stays stable while a
    // transaction is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eeprom_config_data <= '0;
            i2c_start          <= 1'b0;
            busy               <= 1'b0;
            pass               <= 1'b0;
            fail               <= 1'b0;
            err_cnt            <= '0;
            last_rd_data       <= '0;
            idx                <= '0;
        end else begin
            i2c_start <= ld_wr | ld_rd;
            if (accept) begin
                idx     <= '0;
                err_cnt <= '0;
                pass    <= 1'b0;
                fail    <= 1'b0;
                busy    <= 1'b1;
            end
            if (ld_wr) eeprom_config_data <= mk_cmd(DEV_ADDR, RW_WR, addr, pattern);
            if (ld_rd) eeprom_config_data <= mk_cmd(DEV_ADDR, RW_RD, addr, 8'h00);
            if (idx_clr) idx <= '0;
            if (idx_inc) idx <= idx + 8'd1;
            if (cap_rd)  last_rd_data <= i2c_rd_data;
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (finish) begin
                pass <= (err_cnt == 8'h00);
                fail <= (err_cnt != 8'h00);
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eeprom_bist_seq.sv
// Scoreboard bench for eeprom_bist_seq with an ideal byte-controller model;
// honours EEPROM_BIST_STOP_ON_ERR_EN for the corrupted-readback expectations.
module tb_eeprom_bist_seq;

    localparam int          NB   = 4;
    localparam logic [15:0] BASE = 16'hFFFE;

    typedef struct {
        logic       ps;
        logic       fl;
        logic [7:0] err;
        logic [7:0] last;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        test_start = 1'b0;
    logic [31:0] cfg;
    logic        i2c_start;
    logic        i2c_done;
    logic [7:0]  rd_data;
    logic        busy, pass, fail;
    logic [7:0]  err_cnt, last_rd_data;

    always #5 clk = ~clk;

    eeprom_bist_seq #(
        .CLK_FREQ  (50_000_000),
        .TWR_US    (5),
        .NUM_BYTES (NB),
        .BASE_ADDR (BASE),
        .DEV_ADDR  (7'h50),
        .SEED      (8'hA5)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .test_start         (test_start),
        .eeprom_config_data (cfg),
        .i2c_start          (i2c_start),
        .i2c_done           (i2c_done),
        .i2c_rd_data        (rd_data),
        .busy               (busy),
        .pass               (pass),
        .fail               (fail),
        .err_cnt            (err_cnt),
        .last_rd_data       (last_rd_data)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Byte-controller model: ideal memory, done 100 cycles after the strobe.
    logic        mdl_pend, mdl_done;
    logic        spur_done = 1'b0;
    bit          corrupt = 1'b0;
    logic [31:0] mdl_cmd;
    int          mdl_cnt;
    bit   [7:0]  mem [0:65535];

    assign i2c_done = mdl_done | spur_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_pend <= 1'b0;
            mdl_done <= 1'b0;
            mdl_cnt  <= 0;
            rd_data  <= 8'h00;
        end else begin
            mdl_done <= 1'b0;
            if (i2c_start) begin
                mdl_pend <= 1'b1;
                mdl_cnt  <= 99;
                mdl_cmd  <= cfg;
            end else if (mdl_pend) begin
                if (mdl_cnt == 0) begin
                    mdl_pend <= 1'b0;
                    mdl_done <= 1'b1;
                    if (mdl_cmd[24])
                        rd_data <= mem[mdl_cmd[23:8]] ^
                                   ((corrupt && mdl_cmd[23:8] == 16'h0000) ? 8'hFF : 8'h00);
                    else
                        mem[mdl_cmd[23:8]] <= mdl_cmd[7:0];
                end else begin
                    mdl_cnt <= mdl_cnt - 1;
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] cmd_q[$];
    res_t        res_q[$];

    // Monitor: commands and end-of-test results against the queues, plus the
    // intervening-cycle gaps after each done.
    bit   prev_busy = 0, prev_start = 0, done_vld = 0, done_rd = 0;
    int   done_cyc = 0;
    always @(negedge clk) begin
        logic [31:0] e;
        res_t        r;
        if (!rst_n) begin
            prev_busy  = 0;
            prev_start = 0;
            done_vld   = 0;
        end else begin
            if (i2c_start) begin
                chk("start_width", 32'(prev_start), 0);
                chk("no_outstanding", 32'(mdl_pend), 0);
                if (cmd_q.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    e = cmd_q.pop_front();
                    chk("cmd_word", cfg, e);
                end
                if (done_vld) begin
                    if (done_rd) chk("rd_gap", 32'(cyc - done_cyc - 1), 2);
                    else         chk("wr_gap", 32'(cyc - done_cyc - 1), 251);
                    done_vld = 0;
                end
            end
            if (prev_busy && !busy) begin
                if (res_q.size() == 0) chk("unexpected_end", 1, 0);
                else begin
                    r = res_q.pop_front();
                    chk("pass", 32'(pass), 32'(r.ps));
                    chk("fail", 32'(fail), 32'(r.fl));
                    chk("err_cnt", 32'(err_cnt), 32'(r.err));
                    chk("last_rd_data", 32'(last_rd_data), 32'(r.last));
                end
                if (done_vld) chk("end_gap", 32'(cyc - done_cyc - 1), 2);
                done_vld = 0;
            end
            if (mdl_done) begin
                done_vld = 1;
                done_rd  = mdl_cmd[24];
                done_cyc = cyc;
            end
            prev_busy  = busy;
            prev_start = i2c_start;
        end
    end

    // DEV 0x50 in [31:25] gives 0xA0 (write) / 0xA1 (read) in the top byte.
    logic [31:0] wr_cmd [4] = '{32'hA0FFFEA5, 32'hA0FFFFA4, 32'hA00000A7, 32'hA00001A6};
    logic [31:0] rd_cmd [4] = '{32'hA1FFFE00, 32'hA1FFFF00, 32'hA1000000, 32'hA1000100};

    task automatic push_test(input int nrd, input logic ps, input logic [7:0] err,
                             input logic [7:0] last);
        res_t r;
        for (int i = 0; i < 4; i++) cmd_q.push_back(wr_cmd[i]);
        for (int i = 0; i < nrd; i++) cmd_q.push_back(rd_cmd[i]);
        r.ps = ps; r.fl = ~ps; r.err = err; r.last = last;
        res_q.push_back(r);
    endtask

    task automatic pulse_start();
        test_start = 1'b1;
        @(negedge clk);
        test_start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(busy), 0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_cfg"}, cfg, 0);
        chk({nm, "_start"}, 32'(i2c_start), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_pass"}, 32'(pass), 0);
        chk({nm, "_fail"}, 32'(fail), 0);
        chk({nm, "_err"}, 32'(err_cnt), 0);
        chk({nm, "_last"}, 32'(last_rd_data), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        // Spurious done while idle must not start anything.
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("spur_busy", 32'(busy), 0);
        chk("spur_last", 32'(last_rd_data), 0);

        // Clean run across the 16-bit address wrap; extra pulses while busy.
        push_test(4, 1'b1, 8'h00, 8'hA6);
        pulse_start();
        chk("busy_n1", 32'(busy), 1);
        chk("start_n1", 32'(i2c_start), 0);
        @(negedge clk);
        chk("start_n2", 32'(i2c_start), 1);
        chk("cfg_n2", cfg, 32'hA0FFFEA5);
        repeat (20) @(negedge clk);
        pulse_start();
        repeat (400) @(negedge clk);
        pulse_start();
        wait_idle(6000);

        // Corrupted readback at address 0000, test_start held 10 cycles.
        corrupt = 1'b1;
`ifdef EEPROM_BIST_STOP_ON_ERR_EN
        push_test(3, 1'b0, 8'h01, 8'h58);
`else
        push_test(4, 1'b0, 8'h01, 8'hA6);
`endif
        test_start = 1'b1;
        repeat (10) @(negedge clk);
        test_start = 1'b0;
        wait_idle(6000);
        repeat (5) @(negedge clk);
        chk("fail_sticky", 32'(fail), 1);
        chk("no_restart", 32'(busy), 0);
        corrupt = 1'b0;

        // Reset while a read is outstanding.
        push_test(4, 1'b1, 8'h00, 8'hA6);
        pulse_start();
        n = 0;
        while (!(i2c_start && cfg[24]) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("rd_start_timeout", 32'(i2c_start && cfg[24]), 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        cmd_q.delete();
        res_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fresh run after reset.
        push_test(4, 1'b1, 8'h00, 8'hA6);
        pulse_start();
        wait_idle(6000);
        repeat (5) @(negedge clk);
        chk("cmd_q_left", 32'(cmd_q.size()), 0);
        chk("res_q_left", 32'(res_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/eeprom_bist_seq.md
# eeprom_bist_seq

Self-test sequencer for the I2C EEPROM path. It sits directly upstream of the I2C EEPROM byte controller, which it drives through the 32-bit config word and start/done handshake. On a start pulse it writes a known pattern to a block of EEPROM addresses, honouring the write-cycle time after each byte. It then reads the block back, compares each byte, and reports pass/fail, an error count and the last byte read, for display on the seven-segment stage.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- TWR_US, 5: EEPROM internal write-cycle wait, in microseconds.
- NUM_BYTES, 16: bytes per test, range 1..256.
- BASE_ADDR, 16'h0000: first EEPROM word address.
- DEV_ADDR, 7'h50: 7-bit I2C device address.
- SEED, 8'hA5: pattern seed.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- test_start  in  1  single-cycle request to run one test.
- eeprom_config_data  out  32  command word to the byte controller. Fields: [31:25] DEV_ADDR, [24] R/W (1 = read), [23:8] word address, [7:0] write data (0 for reads).
- i2c_start  out  1  single-cycle command strobe.
- i2c_done  in  1  single-cycle completion pulse from the byte controller.
- i2c_rd_data  in  8  read byte; valid in the i2c_done cycle of a read.
- busy  out  1  high from test acceptance until the end of the test.
- pass  out  1  sticky; set at test end when err_cnt == 0.
- fail  out  1  sticky; set at test end when err_cnt != 0.
- err_cnt  out  8  count of mismatches in the current test.
- last_rd_data  out  8  most recent byte read back.

## Operation
- States: IDLE, WR_REQ, WR_WAIT, TWR_DLY, RD_REQ, RD_WAIT, CMP, FINISH.
- Index idx runs 0..NUM_BYTES-1.
  - Address = BASE_ADDR + idx, modulo 2^16; it wraps 16'hFFFF -> 16'h0000.
  - Pattern = idx[7:0] ^ SEED.
- IDLE:
  - On test_start, clear idx, err_cnt, pass and fail; set busy; go to WR_REQ.
  - test_start in any other state is ignored.
- WR_REQ:
  - Load a write command into eeprom_config_data and pulse i2c_start for one cycle.
  - Go to WR_WAIT.
- WR_WAIT:
  - Wait for i2c_done, then go to TWR_DLY.
  - eeprom_config_data is held stable throughout.
- TWR_DLY:
  - Count CLK_FREQ/1_000_000*TWR_US cycles (250 at defaults).
  - If idx is the last index, clear idx and go to RD_REQ; otherwise idx++ and go to WR_REQ.
- RD_REQ:
  - Load a read command and pulse i2c_start; go to RD_WAIT.
- RD_WAIT:
  - On i2c_done, capture i2c_rd_data into last_rd_data; go to CMP.
- CMP:
  - If last_rd_data differs from the pattern, err_cnt++; err_cnt saturates at 8'hFF.
  - If idx is the last index, go to FINISH; otherwise idx++ and go to RD_REQ.
- FINISH:
  - Set pass or fail, clear busy, go to IDLE.
- i2c_done in IDLE, WR_REQ, RD_REQ, TWR_DLY, CMP or FINISH is ignored.
- There is no timeout. A missing i2c_done stalls the sequencer in a WAIT state until reset.

## Timing
- Reset values:
  - eeprom_config_data = 0, i2c_start = 0, busy = 0, pass = 0, fail = 0.
  - err_cnt = 0, last_rd_data = 0, state = IDLE.
- test_start in cycle N:
  - busy rises in N+1.
  - The first i2c_start pulse is in N+2, with eeprom_config_data already valid in that cycle.
- i2c_start is exactly one cycle wide. It never asserts while a command is outstanding.
- Minimum gap from i2c_done to the next i2c_start:
  - Writes: TWR count + 1 cycles.
  - Reads: 2 cycles (CMP, then RD_REQ).
- Final read: pass/fail are set and busy falls 2 cycles after its i2c_done (CMP, then FINISH).
- Reset mid-operation: all state returns to the reset values immediately. The byte controller shares rst_n, so no I2C transaction is left half-issued from this side.

## Configuration
- Macro: EEPROM_BIST_STOP_ON_ERR_EN.
- Defined: the first mismatch in CMP goes straight to FINISH. fail = 1, err_cnt = 1, and idx holds the failing index; the remaining reads are skipped.
- Undefined: every byte is read and compared, and err_cnt holds the total number of mismatches.

## Structure
- Shared package eeprom_pkg:
  - State enum.
  - Config-word field offsets (DEV_MSB = 31, RW_BIT = 24, ADDR_MSB = 23, ADDR_LSB = 8, DATA_MSB = 7).
  - The RD/WR encoding constants.
- Sub-module eeprom_twr_timer: load/count/expire down-counter, parameterised by cycle count, used in TWR_DLY.

## Test plan
- Byte-controller model with ideal memory, 100-cycle done latency, NUM_BYTES = 4, test_start pulse -> 4 writes with data A5, A4, A7, A6 at addresses 0..3, then 4 reads; pass = 1, err_cnt = 0, last_rd_data = A6.
- Model corrupts the byte at address 2 on readback -> fail = 1, err_cnt = 1. With EEPROM_BIST_STOP_ON_ERR_EN defined, only 3 i2c_start reads are issued.
- Write done to next start gap -> exactly 251 cycles at the default parameters.
- BASE_ADDR = 16'hFFFE, NUM_BYTES = 4 -> addresses FFFE, FFFF, 0000, 0001.
- test_start held for 10 cycles and re-pulsed while busy -> only one test runs; spurious i2c_done in IDLE -> no state change.
- rst_n asserted during RD_WAIT -> all outputs return to 0 asynchronously; a fresh test_start then completes with pass = 1.
